sad_accum: RTL
==============

# sad_accum

Downstream stage of `sub_abs_sub`. It consumes the stream of 8-bit absolute-difference results (`res`) and accumulates them over fixed-length blocks. For each block it emits the sum of absolute differences (SAD), the block maximum and the sample count through a valid/ready output register. A flush input closes a block early.

## Interface
- `DATA_W`, 8, width of each input sample (matches `sub_abs_sub` `res`).
- `BLOCK_LEN`, 16, samples per block; must be a power of two, ≥2.
- `CNT_W`, `$clog2(BLOCK_LEN+1)` (5), width of the count field.
- `SUM_W`, `DATA_W+$clog2(BLOCK_LEN)` (12), width of the sum; the maximum sum 255·16=4080 fits, so no saturation.

Ports:
- `clk`  in  1  the single clock; all logic is on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_data`  in  DATA_W  absolute-difference sample.
- `in_ready`  out  1  block accepts a sample this cycle.
- `flush`  in  1  synchronous; close the current partial block.
- `out_valid`  out  1  result register holds an unconsumed result.
- `out_ready`  in  1  consumer takes the result this cycle.
- `out_sum`  out  SUM_W  SAD of the emitted block.
- `out_max`  out  DATA_W  largest sample in the emitted block.
- `out_count`  out  CNT_W  number of samples in the emitted block (1..BLOCK_LEN).

## Operation
- States:
  - ACCUM: collecting samples.
  - HOLD: result presented, waiting for the consumer.
- A sample is accepted when `in_valid && in_ready`.
- `in_ready` = (state==ACCUM); it is a registered-state decode only, with no combinational path from `out_ready`.
- Internal registers are `acc_sum` (SUM_W), `acc_max` (DATA_W) and `acc_cnt` (CNT_W). All three are zero on entering ACCUM.
- ACCUM, on an accepted sample:
  - `acc_sum += in_data`.
  - `acc_max = max(acc_max, in_data)`.
  - `acc_cnt += 1`.
- Block close: the block closes in the cycle the BLOCK_LEN-th sample is accepted, or the cycle `flush`=1 with (`acc_cnt`>0 or a sample accepted).
  - On close, the output registers load the updated values, including the sample accepted that cycle.
  - On close, `out_valid` is set to 1, the accumulators clear, and the state moves to HOLD.
- `flush` with `acc_cnt`=0 and no accepted sample is ignored; no empty result is ever emitted.
- `flush` in HOLD is ignored and is not remembered.
- HOLD:
  - Outputs remain stable while `out_valid && !out_ready`.
  - On `out_valid && out_ready`, `out_valid` clears and the state returns to ACCUM.
  - `in_data` is ignored while in HOLD.
- The output data registers keep their last values after consumption; only `out_valid` qualifies them.
- Reset (asynchronous assert, at any time including mid-block or in HOLD):
  - State goes to ACCUM and all accumulators go to 0.
  - `out_valid`=0, `out_sum`=0, `out_max`=0, `out_count`=0.
  - `in_ready`=1 immediately after deassertion.
  - A partially accumulated block is discarded.

## Timing
- Input-to-result latency: the result is visible one cycle after the edge that accepts the closing sample (`out_valid` is registered).
- Throughput: BLOCK_LEN accepted samples, then at least one HOLD cycle.
  - With `out_ready` held at 1, HOLD lasts exactly one cycle, so a 16-sample block occupies 17 cycles.
  - `in_ready` is low for every HOLD cycle.
- Back-pressure: each extra cycle of `out_ready`=0 in HOLD adds one cycle with `in_ready`=0. No sample is ever lost or duplicated.
- `in_valid` may drop between samples; gaps do not affect the result or the count.

## Test plan
- Full block: reset low for 5 ns, release, then drive 16 consecutive samples of 77 (|123−200|) with `out_ready`=1.
  - Required: `out_valid` pulses one cycle, with `out_sum`=1232, `out_max`=77, `out_count`=16.
  - Required: `in_ready` is 0 for exactly that cycle.
- Ramp with gaps: samples 0..15 with `in_valid` toggling every other cycle.
  - Required: `out_sum`=120, `out_max`=15, `out_count`=16.
- Flush: 3 samples (10, 250, 5) with `flush`=1 on the cycle of the third sample.
  - Required: `out_sum`=265, `out_max`=250, `out_count`=3.
- Flush with no data: `flush` asserted in ACCUM with `acc_cnt`=0.
  - Required: `out_valid` stays 0.
  - Required: the next full block of 16×255 gives `out_sum`=4080 (overflow boundary), `out_max`=255, `out_count`=16.
- Back-pressure: after a block closes, hold `out_ready`=0 for 5 cycles while `in_valid`=1 with value 9.
  - Required: outputs stable, `in_ready`=0, and no 9s counted.
  - Required: after the handshake, the next block counts from 0.
- Mid-block reset: pull `rst` low asynchronously (between edges) after 7 of 16 samples.
  - Required: all outputs are 0 immediately.
  - Required: after release, 16 samples of 1 give `out_sum`=16, `out_count`=16.

Source files
------------

// File: rtl/sad_accum.sv
// Block accumulator for absolute-difference samples: emits SAD, block maximum and
// sample count per block through a valid/ready result register.
module sad_accum #(
    parameter int DATA_W    = 8,
    parameter int BLOCK_LEN = 16,
    parameter int CNT_W     = $clog2(BLOCK_LEN + 1),
    parameter int SUM_W     = DATA_W + $clog2(BLOCK_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SUM_W-1:0]  out_sum,
    output logic [DATA_W-1:0] out_max,
    output logic [CNT_W-1:0]  out_count
);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t            state, state_n;
    logic [SUM_W-1:0]  acc_sum, acc_sum_n, upd_sum;
    logic [DATA_W-1:0] acc_max, acc_max_n, upd_max;
    logic [CNT_W-1:0]  acc_cnt, acc_cnt_n, upd_cnt;
    logic              out_valid_n;
    logic [SUM_W-1:0]  out_sum_n;
    logic [DATA_W-1:0] out_max_n;
    logic [CNT_W-1:0]  out_count_n;
    logic              accept, close;

    assign in_ready = (state == ACCUM);
    assign accept   = in_valid && in_ready;

    // Updated values include the sample accepted this cycle, so a closing block
    // reports its final sample without an extra cycle.
    always_comb begin
        upd_sum = acc_sum;
        upd_max = acc_max;
        upd_cnt = acc_cnt;
        if (accept) begin
            upd_sum = acc_sum + SUM_W'(in_data);
            upd_max = (in_data > acc_max) ? in_data : acc_max;
            upd_cnt = acc_cnt + CNT_W'(1);
        end
    end

    assign close = (state == ACCUM) &&
                   ((accept && (upd_cnt == CNT_W'(BLOCK_LEN))) ||
                    (flush && ((acc_cnt != '0) || accept)));

    always_comb begin
        state_n     = state;
        acc_sum_n   = acc_sum;
        acc_max_n   = acc_max;
        acc_cnt_n   = acc_cnt;
        out_valid_n = out_valid;
        out_sum_n   = out_sum;
        out_max_n   = out_max;
        out_count_n = out_count;
        case (state)
            ACCUM: begin
                if (close) begin
                    state_n     = HOLD;
                    out_valid_n = 1'b1;
                    out_sum_n   = upd_sum;
                    out_max_n   = upd_max;
                    out_count_n = upd_cnt;
                    acc_sum_n   = '0;
                    acc_max_n   = '0;
                    acc_cnt_n   = '0;
                end else begin
                    acc_sum_n = upd_sum;
                    acc_max_n = upd_max;
                    acc_cnt_n = upd_cnt;
                end
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    state_n     = ACCUM;
                    out_valid_n = 1'b0;
                end
            end
            default: state_n = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ACCUM;
            acc_sum   <= '0;
            acc_max   <= '0;
            acc_cnt   <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_max   <= '0;
            out_count <= '0;
        end else begin
            state     <= state_n;
            acc_sum   <= acc_sum_n;
            acc_max   <= acc_max_n;
            acc_cnt   <= acc_cnt_n;
            out_valid <= out_valid_n;
            out_sum   <= out_sum_n;
            out_max   <= out_max_n;
            out_count <= out_count_n;
        end
    end

endmodule
